// File: rtl/bscan_tap_ctrl.sv
// rtl/bscan_tap_ctrl.sv - IEEE 1149.1-style TAP controller driving an external boundary-scan chain
//
// Ports:
//   clk, rst        TCK and asynchronous active-high TAP reset (TRST equivalent)
//   tms, tdi        test mode select / test data in
//   tdo, tdo_en     test data out (combinational from state) and its enable (Shift-DR/IR)
//   bsr_si, bsr_so  serial in to / serial out from the external boundary-scan register
//   bsr_capture_en  capture pulse for BSR cells (Capture-DR with EXTEST/SAMPLE selected)
//   bsr_shift_dr    shift select for BSR cells (Shift-DR with EXTEST/SAMPLE selected)
//   bsr_update_en   update pulse for BSR cells (Update-DR with EXTEST/SAMPLE selected)
//   bsr_mode        1 while EXTEST is the current instruction
//   instr           current (updated) instruction
module bscan_tap_ctrl #(
  parameter int unsigned          IR_WIDTH     = 4,
  parameter logic [31:0]          IDCODE_VALUE = 32'h0000_0001,
  parameter logic [IR_WIDTH-1:0]  OP_EXTEST    = IR_WIDTH'(0),
  parameter logic [IR_WIDTH-1:0]  OP_SAMPLE    = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0]  OP_IDCODE    = IR_WIDTH'(2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic                bsr_si,
  input  logic                bsr_so,
  output logic                bsr_capture_en,
  output logic                bsr_shift_dr,
  output logic                bsr_update_en,
  output logic                bsr_mode,
  output logic [IR_WIDTH-1:0] instr
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_t;

  // The fixed 2'b01 pattern the IR captures, zero-extended to the IR width.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  tap_state_t          state;
  tap_state_t          state_nxt;
  logic [IR_WIDTH-1:0] ir_sr;
  logic                bypass_q;
  logic [31:0]         idcode_sr;

  logic sel_bsr;
  logic sel_idcode;
  logic sel_bypass;

  // Data register selection: anything that is not a defined opcode falls to bypass.
  assign sel_bsr    = (instr == OP_EXTEST) || (instr == OP_SAMPLE);
  assign sel_idcode = (instr == OP_IDCODE);
  assign sel_bypass = !sel_bsr && !sel_idcode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TLR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      TLR:    state_nxt = tms ? TLR    : RTI;
      RTI:    state_nxt = tms ? SEL_DR : RTI;
      SEL_DR: state_nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_nxt = tms ? EX1_DR : SH_DR;
      SH_DR:  state_nxt = tms ? EX1_DR : SH_DR;
      EX1_DR: state_nxt = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_nxt = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_nxt = tms ? UPD_DR : SH_DR;
      UPD_DR: state_nxt = tms ? SEL_DR : RTI;
      SEL_IR: state_nxt = tms ? TLR    : CAP_IR;
      CAP_IR: state_nxt = tms ? EX1_IR : SH_IR;
      SH_IR:  state_nxt = tms ? EX1_IR : SH_IR;
      EX1_IR: state_nxt = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_nxt = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_nxt = tms ? UPD_IR : SH_IR;
      UPD_IR: state_nxt = tms ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  // Instruction register. instr only moves on leaving UPD_IR or on any FSM
  // entry into TLR; a partially shifted IR is never applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_sr <= '0;
      instr <= OP_IDCODE;
    end else begin
      if (state == CAP_IR) begin
        ir_sr <= IR_CAPTURE;
      end else if (state == SH_IR) begin
        ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
      end

      if (state_nxt == TLR) begin
        instr <= OP_IDCODE;
      end else if (state == UPD_IR) begin
        instr <= ir_sr;
      end
    end
  end

  // Internal data registers; only the one selected by instr moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bypass_q  <= 1'b0;
      idcode_sr <= IDCODE_VALUE;
    end else begin
      if (state == CAP_DR) begin
        if (sel_idcode) begin
          idcode_sr <= IDCODE_VALUE;
        end else if (sel_bypass) begin
          bypass_q <= 1'b0;
        end
      end else if (state == SH_DR) begin
        if (sel_idcode) begin
          idcode_sr <= {tdi, idcode_sr[31:1]};
        end else if (sel_bypass) begin
          bypass_q <= tdi;
        end
      end
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (state == SH_IR) begin
      tdo = ir_sr[0];
    end else if (state == SH_DR) begin
      if (sel_bsr) begin
        tdo = bsr_so;
      end else if (sel_idcode) begin
        tdo = idcode_sr[0];
      end else begin
        tdo = bypass_q;
      end
    end
  end

  assign tdo_en         = (state == SH_DR) || (state == SH_IR);
  assign bsr_si         = tdi;
  assign bsr_capture_en = (state == CAP_DR) && sel_bsr;
  assign bsr_shift_dr   = (state == SH_DR)  && sel_bsr;
  assign bsr_update_en  = (state == UPD_DR) && sel_bsr;
  assign bsr_mode       = (instr == OP_EXTEST);

endmodule

// File: tb/tb_bscan_tap_ctrl.sv
// tb/tb_bscan_tap_ctrl.sv - self-checking bench for bscan_tap_ctrl
module tb_bscan_tap_ctrl;

  localparam int          W   = 4;
  localparam logic [31:0] IDC = 32'h0000_0001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tms = 1'b1;
  logic         tdi = 1'b0;
  logic         bsr_so = 1'b0;
  logic         tdo, tdo_en, bsr_si, bsr_capture_en, bsr_shift_dr, bsr_update_en, bsr_mode;
  logic [W-1:0] instr;

  bscan_tap_ctrl dut (
    .clk(clk), .rst(rst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .bsr_si(bsr_si), .bsr_so(bsr_so), .bsr_capture_en(bsr_capture_en),
    .bsr_shift_dr(bsr_shift_dr), .bsr_update_en(bsr_update_en),
    .bsr_mode(bsr_mode), .instr(instr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: TAP states as plain numbers with transition tables taken
  // straight from the state diagram; IR/DR contents kept as LSB-first bit queues.
  localparam int S_TLR = 0, S_RTI = 1, S_CDR = 3, S_SHDR = 4, S_UDR = 8;
  localparam int S_CIR = 10, S_SHIR = 11, S_UIR = 15;
  int nx0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int m_state;
  int m_instr;
  bit ir_q[$];
  bit dr_q[$];

  function automatic bit m_bsr_sel();
    return (m_instr == 0) || (m_instr == 1);
  endfunction

  task automatic m_reset();
    m_state = S_TLR;
    m_instr = 2;
    ir_q.delete();
    for (int i = 0; i < W; i++) ir_q.push_back(1'b0);
    dr_q.delete();
  endtask

  task automatic m_step(input logic t, input logic d);
    logic [31:0] idv;
    idv = IDC;
    case (m_state)
      S_CIR: begin
        ir_q.delete();
        ir_q.push_back(1'b1);
        for (int i = 1; i < W; i++) ir_q.push_back(1'b0);
      end
      S_SHIR: begin
        void'(ir_q.pop_front());
        ir_q.push_back(d);
      end
      S_UIR: begin
        m_instr = 0;
        for (int i = 0; i < W; i++) m_instr += int'(ir_q[i]) << i;
      end
      S_CDR: begin
        dr_q.delete();
        if (!m_bsr_sel()) begin
          if (m_instr == 2) for (int i = 0; i < 32; i++) dr_q.push_back(idv[i]);
          else dr_q.push_back(1'b0);
        end
      end
      S_SHDR: begin
        if (!m_bsr_sel() && dr_q.size() > 0) begin
          void'(dr_q.pop_front());
          dr_q.push_back(d);
        end
      end
      default: ;
    endcase
    m_state = t ? nx1[m_state] : nx0[m_state];
    if (m_state == S_TLR) m_instr = 2;
  endtask

  // {tdo, tdo_en, capture, shift, update, mode, instr}
  function automatic logic [9:0] m_expect(input logic so);
    logic e_tdo;
    logic sel;
    logic [W-1:0] ins;
    sel = m_bsr_sel();
    ins = W'(m_instr);
    e_tdo = 1'b0;
    if (m_state == S_SHIR) e_tdo = ir_q[0];
    else if (m_state == S_SHDR) e_tdo = sel ? so : ((dr_q.size() > 0) ? dr_q[0] : 1'b0);
    return {e_tdo, (m_state == S_SHIR) || (m_state == S_SHDR),
            (m_state == S_CDR) && sel, (m_state == S_SHDR) && sel,
            (m_state == S_UDR) && sel, (m_instr == 0), ins};
  endfunction

  logic [9:0] o_vec;
  logic [9:0] e_vec;
  logic       o_si;

  // One TCK: drive on the falling edge, sample 1 time unit later, advance model on the rising edge.
  task automatic tick(input logic r, input logic t, input logic d, input logic s);
    @(negedge clk);
    rst = r; tms = t; tdi = d; bsr_so = s;
    #1;
    if (r) m_reset();
    o_vec = {tdo, tdo_en, bsr_capture_en, bsr_shift_dr, bsr_update_en, bsr_mode, instr};
    o_si  = bsr_si;
    e_vec = m_expect(s);
    @(posedge clk);
    if (!r) m_step(t, d);
  endtask

  typedef struct {
    logic       r, t, d, s;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[25];

  task automatic setv(input int i, input logic r, input logic t, input logic d,
                      input logic s, input logic [9:0] e);
    tbl[i].r = r; tbl[i].t = t; tbl[i].d = d; tbl[i].s = s; tbl[i].exp = e;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] word;
    int          en_cnt;
    logic [2:0]  bseq;
    logic [2:0]  sh_seen;

    m_reset();

    // Reset, load EXTEST through the IR, run a BSR DR scan, then 5x tms=1 back to TLR.
    setv(0,  1, 0, 0, 0, 10'b00_000_0_0010);
    setv(1,  0, 0, 0, 0, 10'b00_000_0_0010);
    setv(2,  0, 1, 0, 0, 10'b00_000_0_0010);
    setv(3,  0, 1, 0, 0, 10'b00_000_0_0010);
    setv(4,  0, 0, 0, 0, 10'b00_000_0_0010);
    setv(5,  0, 0, 0, 0, 10'b00_000_0_0010);
    setv(6,  0, 0, 0, 0, 10'b11_000_0_0010);
    setv(7,  0, 0, 0, 0, 10'b01_000_0_0010);
    setv(8,  0, 0, 0, 0, 10'b01_000_0_0010);
    setv(9,  0, 1, 0, 0, 10'b01_000_0_0010);
    setv(10, 0, 1, 0, 0, 10'b00_000_0_0010);
    setv(11, 0, 0, 0, 0, 10'b00_000_0_0010);
    setv(12, 0, 1, 0, 0, 10'b00_000_1_0000);
    setv(13, 0, 0, 0, 0, 10'b00_000_1_0000);
    setv(14, 0, 0, 0, 0, 10'b00_100_1_0000);
    setv(15, 0, 0, 0, 1, 10'b11_010_1_0000);
    setv(16, 0, 1, 0, 0, 10'b01_010_1_0000);
    setv(17, 0, 1, 0, 0, 10'b00_000_1_0000);
    setv(18, 0, 0, 0, 0, 10'b00_001_1_0000);
    setv(19, 0, 0, 0, 0, 10'b00_000_1_0000);
    setv(20, 0, 1, 0, 0, 10'b00_000_1_0000);
    setv(21, 0, 1, 0, 0, 10'b00_000_1_0000);
    setv(22, 0, 1, 0, 0, 10'b00_000_1_0000);
    setv(23, 0, 1, 0, 0, 10'b00_000_0_0010);
    setv(24, 0, 1, 0, 0, 10'b00_000_0_0010);

    for (int i = 0; i < 25; i++) begin
      tick(tbl[i].r, tbl[i].t, tbl[i].d, tbl[i].s);
      chk($sformatf("vec[%0d]", i), 32'(o_vec), 32'(tbl[i].exp));
    end

    // IDCODE scan: 32 shifts of tdi=0, exit on the 32nd.
    en_cnt = 0;
    word = '0;
    tick(0, 0, 0, 0); en_cnt += int'(o_vec[8]);
    tick(0, 1, 0, 0); en_cnt += int'(o_vec[8]);
    tick(0, 0, 0, 0); en_cnt += int'(o_vec[8]);
    tick(0, 0, 0, 0); en_cnt += int'(o_vec[8]);
    for (int i = 0; i < 32; i++) begin
      tick(0, (i == 31), 0, 0);
      word[i] = o_vec[9];
      en_cnt += int'(o_vec[8]);
    end
    tick(0, 1, 0, 0); en_cnt += int'(o_vec[8]);
    tick(0, 0, 0, 0); en_cnt += int'(o_vec[8]);
    tick(0, 0, 0, 0); en_cnt += int'(o_vec[8]);
    chk("idcode_word", word, IDC);
    chk("idcode_tdo_en_cycles", 32'(en_cnt), 32'd32);

    // Load all-ones (BYPASS) and check the one-clock delay path.
    tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, (i == 3), 1, 0);
    tick(0, 1, 0, 0); tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("bypass_instr", 32'(o_vec[3:0]), 32'hF);
    tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    tick(0, 0, 1, 1); bseq[0] = o_vec[9]; sh_seen[0] = o_vec[6];
    tick(0, 0, 0, 1); bseq[1] = o_vec[9]; sh_seen[1] = o_vec[6];
    tick(0, 1, 1, 1); bseq[2] = o_vec[9]; sh_seen[2] = o_vec[6];
    chk("bypass_tdo_seq", 32'(bseq), 32'b010);
    chk("bypass_no_bsr_shift", 32'(sh_seen), 32'd0);
    tick(0, 1, 0, 0); tick(0, 0, 0, 0);

    // rst during SH_IR after 2 bits: immediate TLR, partial IR discarded.
    tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("midshift_tdo_en_before", 32'(o_vec[8]), 32'd1);
    tick(1, 0, 0, 0);
    chk("midshift_rst_instr", 32'(o_vec[3:0]), 32'd2);
    chk("midshift_rst_tdo_en", 32'(o_vec[8]), 32'd0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("midshift_after_instr", 32'(o_vec[3:0]), 32'd2);

    // Randomized walk against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic r, t, d, s;
      r = ($urandom_range(0, 249) == 0);
      t = ($urandom_range(0, 99) < 35);
      d = 1'($urandom);
      s = 1'($urandom);
      tick(r, t, d, s);
      chk($sformatf("rand[%0d]", i), 32'({o_vec, o_si}), 32'({e_vec, d}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bscan_tap_ctrl.md
Name: bscan_tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller: the initiator side that drives DW_bc_2-type boundary-scan cells.
- Decodes TMS into the 16-state TAP FSM and holds the instruction register (IR), a bypass register and an IDCODE register.
- Generates shift/capture/update/mode controls for an external boundary-scan register (BSR) chain and muxes TDO.
- Single-clock design: TCK is the block clock, and cell capture/update are qualified by enables on the same clock.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
IDCODE_VALUE, 32'h0000_0001, value captured into the IDCODE register (bit 0 must be 1)
OP_EXTEST, 0, EXTEST opcode
OP_SAMPLE, 1, SAMPLE/PRELOAD opcode
OP_IDCODE, 2, IDCODE opcode; also the IR reset value

Ports:
clk  input  1  TCK; all state changes on rising edge
rst  input  1  asynchronous active-high reset (TRST equivalent)
tms  input  1  test mode select
tdi  input  1  test data in
tdo  output  1  test data out
tdo_en  output  1  high in Shift-DR / Shift-IR
bsr_si  output  1  serial in to BSR chain (= tdi)
bsr_so  input  1  serial out from last BSR cell
bsr_capture_en  output  1  BSR capture enable (active-high), asserted in Capture-DR
bsr_shift_dr  output  1  BSR shift select, asserted in Shift-DR
bsr_update_en  output  1  BSR update enable, asserted in Update-DR
bsr_mode  output  1  1 = cells drive test data (EXTEST active)
instr  output  IR_WIDTH  current (updated) instruction

Behaviour:
- Reset (async, rst=1): FSM = TEST_LOGIC_RESET, instr = OP_IDCODE, IR shift reg = 0, bypass = 0, IDCODE shift reg = IDCODE_VALUE. All bsr_* controls = 0, tdo_en = 0, tdo = 0.
- FSM: standard 16 states, advanced on each rising clk by tms. Transitions on tms=1/tms=0:
  - TLR -> TLR / RTI; RTI -> SEL_DR / RTI
  - SEL_DR -> SEL_IR / CAP_DR; CAP_DR -> EX1_DR / SH_DR; SH_DR -> EX1_DR / SH_DR
  - EX1_DR -> UPD_DR / PAU_DR; PAU_DR -> EX2_DR / PAU_DR; EX2_DR -> UPD_DR / SH_DR
  - UPD_DR -> SEL_DR / RTI; SEL_IR -> TLR / CAP_IR
  - The IR branch mirrors the DR branch.
- Five consecutive tms=1 reach TLR from any state.
- Entering TLR through the FSM (not only via rst) reloads instr = OP_IDCODE.
- Outputs are decoded from the current state (Moore):
  - bsr_capture_en = CAP_DR & bsr_sel; bsr_shift_dr = SH_DR & bsr_sel; bsr_update_en = UPD_DR & bsr_sel.
  - bsr_sel = instr is OP_EXTEST or OP_SAMPLE.
- bsr_mode = (instr == OP_EXTEST). It changes only on the clock edge leaving UPD_IR or entering TLR.
- IR:
  - CAP_IR loads {0..0,2'b01}.
  - SH_IR shifts right with tdi into the MSB.
  - UPD_IR copies the shift reg to instr.
  - instr never changes in any other state.
- Data registers, selected by instr:
  - Bypass (1 bit): CAP_DR loads 0; SH_DR loads tdi.
  - IDCODE (32 bit): CAP_DR loads IDCODE_VALUE; SH_DR shifts right, tdi into bit 31.
  - BSR: external; only the controls are driven.
- Any opcode that is not one of the three defined opcodes selects bypass, including all-ones BYPASS.
- tdo is combinational from the current state:
  - SH_IR: IR shift reg bit 0.
  - SH_DR: selected DR's LSB (bsr_so for EXTEST/SAMPLE).
  - All other states: 0.
- tdo_en = SH_IR | SH_DR. Any falling-edge retiming is done at integration, not in this block.
- Shift length: an N-bit register is shifted with N clocks in SH_*; the exit is taken on the Nth clock with tms=1.
- Pause states hold all shift registers. Exit states do not shift.
- rst asserted mid-shift: immediate return to the reset values; a partially shifted IR is discarded.

Test Plan:
- rst pulse, then tms=1 for 5 clocks from RTI -> state TLR, instr=2, bsr_mode=0, all bsr_* controls 0.
- From RTI, tms sequence 1,0,0 (CAP_DR), then 32 shifts with tdi=0, last with tms=1 -> tdo yields 32'h0000_0001 LSB-first, tdo_en=1 for exactly 32 clocks.
- Shift IR (IR_WIDTH=4) with tdi=0000, then UPD_IR -> instr=0, bsr_mode=1; first tdo bits from IR = 1,0,0,0.
- With EXTEST: CAP_DR -> bsr_capture_en=1 for exactly 1 clock; SH_DR with bsr_so=1 -> tdo=1; UPD_DR -> bsr_update_en=1 for 1 clock.
- instr=4'hF (BYPASS): shift tdi=1,0,1 -> tdo = 0 (captured),1,0, i.e. one-clock delay; bsr_shift_dr stays 0.
- rst asserted during SH_IR after 2 bits -> immediate TLR, instr=2; the partial IR is not applied.
